soda_vend_ctrl: RTL and testbench

SODA_VEND_CTRL -- requirements
Module: soda_vend_ctrl

---
 rtl/soda_vend_ctrl.sv | 91 +++++++++
 tb/tb_soda_vend_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/soda_vend_ctrl.sv
// Soda vending controller: sums nickel/dime/quarter pulses into a credit and
// dispenses with change once PRICE is reached. Define SODA_VEND_CANCEL_EN to enable cancel/refund.
module soda_vend_ctrl #(
    parameter int unsigned PRICE    = 4,
    parameter int unsigned CREDIT_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                nickle_i,
    input  logic                dime_i,
    input  logic                quarter_i,
    input  logic                cancel_i,
    output logic                soda_o,
    output logic [CREDIT_W-1:0] change_o,
    output logic                refund_o,
    output logic [CREDIT_W-1:0] credit_o
);

    // Extra headroom so credit plus the largest deposit never wraps before the compare.
    localparam int unsigned SUM_W = CREDIT_W + 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] VEND    = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                soda_q,   soda_d;
    logic                refund_q, refund_d;

    logic [3:0]       deposit;
    logic [SUM_W-1:0] baseCredit;
    logic [SUM_W-1:0] nextSum;
    logic             cancelHit;

    assign deposit = {3'b000, nickle_i} + {2'b00, dime_i, 1'b0} + {1'b0, quarter_i, 1'b0, quarter_i};

    // Only COLLECT carries credit forward; a coin arriving during VEND starts fresh.
    assign baseCredit = (state_q == COLLECT) ? SUM_W'(credit_q) : '0;
    assign nextSum    = baseCredit + SUM_W'(deposit);

`ifdef SODA_VEND_CANCEL_EN
    assign cancelHit = cancel_i && (state_q != VEND) && (nextSum != '0);
`else
    logic unusedCancel;
    assign unusedCancel = cancel_i;
    assign cancelHit    = 1'b0;
`endif

    always_comb begin
        state_d  = IDLE;
        credit_d = '0;
        change_d = '0;
        soda_d   = 1'b0;
        refund_d = 1'b0;
        if (cancelHit) begin
            refund_d = 1'b1;
            change_d = CREDIT_W'(nextSum);
        end else if (nextSum >= SUM_W'(PRICE)) begin
            state_d  = VEND;
            soda_d   = 1'b1;
            change_d = CREDIT_W'(nextSum - SUM_W'(PRICE));
        end else if (nextSum != '0) begin
            state_d  = COLLECT;
            credit_d = CREDIT_W'(nextSum);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            credit_q <= '0;
            change_q <= '0;
            soda_q   <= 1'b0;
            refund_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            soda_q   <= soda_d;
            refund_q <= refund_d;
        end
    end

    assign soda_o   = soda_q;
    assign change_o = change_q;
    assign refund_o = refund_q;
    assign credit_o = credit_q;

endmodule

// File: tb/tb_soda_vend_ctrl.sv
// Directed-vector bench for soda_vend_ctrl with PRICE=4, CREDIT_W=5.
module tb_soda_vend_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       nickle_i = 1'b0;
    logic       dime_i = 1'b0;
    logic       quarter_i = 1'b0;
    logic       cancel_i = 1'b0;
    logic       soda_o;
    logic [4:0] change_o;
    logic       refund_o;
    logic [4:0] credit_o;

    int vectorCount = 0;
    int missCount   = 0;

    soda_vend_ctrl #(.PRICE(4), .CREDIT_W(5)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .nickle_i (nickle_i),
        .dime_i   (dime_i),
        .quarter_i(quarter_i),
        .cancel_i (cancel_i),
        .soda_o   (soda_o),
        .change_o (change_o),
        .refund_o (refund_o),
        .credit_o (credit_o)
    );

    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int soda, input int change,
                            input int refund, input int credit);
        checkOutput({tag, ".soda"},   int'(soda_o),   soda);
        checkOutput({tag, ".change"}, int'(change_o), change);
        checkOutput({tag, ".refund"}, int'(refund_o), refund);
        checkOutput({tag, ".credit"}, int'(credit_o), credit);
        checkOutput({tag, ".excl"},   int'(soda_o & refund_o), 0);
    endtask

    // Drives one cycle of inputs at the falling edge, then samples just after the rising edge.
    task automatic applyStimulus(input logic n, input logic d, input logic q, input logic c);
        @(negedge clk_i);
        nickle_i  = n;
        dime_i    = d;
        quarter_i = q;
        cancel_i  = c;
        @(posedge clk_i);
        #1;
        nickle_i  = 1'b0;
        dime_i    = 1'b0;
        quarter_i = 1'b0;
        cancel_i  = 1'b0;
    endtask

    initial begin
        #1;
        checkAll("rst_async", 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        checkAll("rst_held", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // dime, dime -> exact price
        applyStimulus(0, 1, 0, 0); checkAll("dd_1", 0, 0, 0, 2);
        applyStimulus(0, 1, 0, 0); checkAll("dd_vend", 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0); checkAll("dd_idle", 0, 0, 0, 0);

        // single quarter
        applyStimulus(0, 0, 1, 0); checkAll("q_vend", 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0); checkAll("q_idle", 0, 0, 0, 0);

        // nickel+dime together, then dime
        applyStimulus(1, 1, 0, 0); checkAll("nd_1", 0, 0, 0, 3);
        applyStimulus(0, 1, 0, 0); checkAll("nd_vend", 1, 1, 0, 0);

        // quarter, quarter during VEND -> back-to-back vends
        applyStimulus(0, 0, 1, 0); checkAll("qq_1", 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 0); checkAll("qq_2", 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0); checkAll("qq_idle", 0, 0, 0, 0);

        // all three coins at once: 8 nickels -> change 4
        applyStimulus(1, 1, 1, 0); checkAll("all_vend", 1, 4, 0, 0);

        // nickels one at a time up to the price
        applyStimulus(1, 0, 0, 0); checkAll("n_1", 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0); checkAll("n_2", 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0); checkAll("n_hold", 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 0); checkAll("n_3", 0, 0, 0, 3);
        applyStimulus(1, 0, 0, 0); checkAll("n_vend", 1, 0, 0, 0);

        // dime, then cancel together with a nickel
        applyStimulus(0, 1, 0, 0); checkAll("c_1", 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 1);
`ifdef SODA_VEND_CANCEL_EN
        checkAll("c_refund", 0, 3, 1, 0);
        applyStimulus(0, 1, 0, 0); checkAll("c_after", 0, 0, 0, 2);
        applyStimulus(0, 1, 0, 0); checkAll("c_after_vend", 1, 0, 0, 0);
`else
        checkAll("c_ignored", 0, 0, 0, 3);
        applyStimulus(0, 1, 0, 0); checkAll("c_after_vend", 1, 1, 0, 0);
`endif

        // cancel in IDLE with no coin, and cancel during VEND
        applyStimulus(0, 0, 0, 1); checkAll("c_idle", 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0); checkAll("cv_vend", 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1); checkAll("cv_ignored", 0, 0, 0, 0);

        // reset mid-transaction discards credit immediately
        applyStimulus(0, 1, 0, 0); checkAll("r_1", 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 0); checkAll("r_2", 0, 0, 0, 3);
        #2;
        rst_i = 1'b0;
        #1;
        checkAll("r_async", 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(0, 1, 0, 0); checkAll("r_after", 0, 0, 0, 2);
        applyStimulus(0, 1, 0, 0); checkAll("r_after_vend", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
